// File: rtl/i2c_srg_p.sv
// I2C byte shifter: MSB-first receive/transmit shift register with bit counting,
// frame capture and masked slave-address / general-call matching on the address frame.
module i2c_srg_p #(
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-2:0] ADDR      = 7'h48,
  parameter logic [DATA_W-2:0] ADDR_MASK = '1,
  parameter bit                GC_EN     = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr_in,
  input  logic                        next_in,
  input  logic                        bit_in,
  input  logic                        load_in,
  input  logic [DATA_W-1:0]           tx_data_in,
  output logic                        bit_out,
  output logic [DATA_W-1:0]           data_out,
  output logic                        byte_done_out,
  output logic                        addrok_out,
  output logic                        gcall_out,
  output logic                        rw_out,
  output logic [$clog2(DATA_W)-1:0]   bitcnt_out
);

  localparam int unsigned       CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  // The only sequencing state: whether the next completed frame is the address frame.
  typedef enum logic {
    PH_ADDR = 1'b0,
    PH_DATA = 1'b1
  } phase_e;

  phase_e             phase_q, phase_d;
  logic [DATA_W-1:0]  srg_r;
  logic [CNT_W-1:0]   bitcnt_r;

  logic [DATA_W-1:0]  frame_next;
  logic [DATA_W-2:0]  frame_addr;
  logic               shift_en;
  logic               frame_done;
  logic               own_match;
  logic               gc_match;

  // Shift is suppressed by clear or load; the completed frame is the post-shift value.
  assign shift_en   = next_in && !clr_in && !load_in;
  assign frame_done = shift_en && (bitcnt_r == LAST_BIT);
  assign frame_next = {srg_r[DATA_W-2:0], bit_in};
  assign frame_addr = frame_next[DATA_W-1:1];

  assign own_match  = ((frame_addr ^ ADDR) & ADDR_MASK) == '0;
  assign gc_match   = GC_EN && (frame_addr == '0);

  assign bit_out    = srg_r[DATA_W-1];
  assign bitcnt_out = bitcnt_r;

  // NOTE: every variable assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    phase_d = phase_q;
    if (clr_in) begin
      phase_d = PH_ADDR;
    end else if (frame_done && (phase_q == PH_ADDR)) begin
      phase_d = PH_DATA;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_ADDR;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srg_r         <= '0;
      bitcnt_r      <= '0;
      data_out      <= '0;
      byte_done_out <= 1'b0;
      addrok_out    <= 1'b0;
      gcall_out     <= 1'b0;
      rw_out        <= 1'b0;
    end else begin
      byte_done_out <= 1'b0;
      if (clr_in) begin
        srg_r      <= '0;
        bitcnt_r   <= '0;
        data_out   <= '0;
        addrok_out <= 1'b0;
        gcall_out  <= 1'b0;
        rw_out     <= 1'b0;
      end else if (load_in) begin
        srg_r    <= tx_data_in;
        bitcnt_r <= '0;
      end else if (next_in) begin
        srg_r <= frame_next;
        if (bitcnt_r == LAST_BIT) begin
          bitcnt_r      <= '0;
          data_out      <= frame_next;
          byte_done_out <= 1'b1;
          // Address flags are captured once per transaction and then held until clear.
          if (phase_q == PH_ADDR) begin
            addrok_out <= own_match | gc_match;
            gcall_out  <= gc_match & ~own_match;
            rw_out     <= frame_next[0];
          end
        end else begin
          bitcnt_r <= bitcnt_r + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/i2c_srg_p.md
Name: i2c_srg_p

Overview:
Parametrised I2C byte shifter for the serial interface. It is the successor to the fixed 8-bit address-check shift register.
- Receives DATA_W-bit frames MSB-first on each bit strobe and tracks bit position.
- Signals frame completion and captures each received frame.
- Performs masked slave-address and general-call matching on the first frame after a clear.
- Supports parallel load for MSB-first transmit.
- Sits between the I2C bit-level controller (supplies next_in, clr_in, load_in) and the register/filter interface.

Parameters:
DATA_W, 8, frame width in bits; legal range 2..16; address width is DATA_W-1
ADDR, 7'h48, slave address compared against frame bits [DATA_W-1:1]
ADDR_MASK, all ones (DATA_W-1 bits), per-bit compare enable; 0 = don't care
GC_EN, 1, 1 = an all-zero address (general call) is accepted

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clr_in  in  1  synchronous clear; starts a new transaction (address phase)
next_in  in  1  one-cycle strobe: shift bit_in into the register
bit_in  in  1  serial data sampled when next_in=1
load_in  in  1  one-cycle strobe: parallel load tx_data_in for transmit
tx_data_in  in  DATA_W  transmit frame
bit_out  out  1  serial transmit bit = srg_r[DATA_W-1]
data_out  out  DATA_W  last completed received frame (held)
byte_done_out  out  1  one-cycle pulse on frame completion
addrok_out  out  1  address matched (own address or general call); held until clear
gcall_out  out  1  match was a general call; held until clear
rw_out  out  1  bit 0 of the address frame (1 = master read); held until clear
bitcnt_out  out  clog2(DATA_W)  bits received in the current frame

Behaviour:
- Reset (rst_n=0, asynchronous):
  - srg_r, bitcnt, data_out, byte_done_out, addrok_out, gcall_out and rw_out go to 0.
  - addr_phase_r goes to 1.
  - bit_out=0.
- Priority on each rising edge: reset > clr_in > load_in > next_in. When load_in and next_in are both high, next_in is ignored.
- clr_in: srg_r, bitcnt and all flags go to 0, and addr_phase_r goes to 1. data_out is also cleared. byte_done_out is 0 in the following cycle.
- load_in: srg_r <= tx_data_in and bitcnt <= 0. Flags and data_out are unchanged.
- next_in (shift):
  - srg_r <= {srg_r[DATA_W-2:0], bit_in}.
  - If bitcnt < DATA_W-1: bitcnt increments.
  - If bitcnt == DATA_W-1: bitcnt wraps to 0 and a frame completes.
- Frame completion. On the same edge as the final shift:
  - data_out <= {srg_r[DATA_W-2:0], bit_in}, the full new frame.
  - byte_done_out is set to 1 for exactly one cycle, then returns to 0 unless another completion occurs.
  - If addr_phase_r=1, with F = the completed frame:
    - own = ((F[DATA_W-1:1] ^ ADDR) & ADDR_MASK) == 0.
    - gc = GC_EN && (F[DATA_W-1:1] == 0).
    - addrok_out <= own | gc.
    - gcall_out <= gc & ~own.
    - rw_out <= F[0].
    - addr_phase_r <= 0.
  - If addr_phase_r=0: the address flags are unchanged.
- Latency:
  - The received frame and flags are visible in the cycle after the edge that samples the DATA_W-th bit.
  - bit_out reflects a load or shift in the cycle after that edge.
- Transmit: after a load, each next_in shifts left, so bit_out presents tx bits MSB-first. Received bits fill from the LSB concurrently, which allows ACK/loopback use.
- Boundary cases:
  - next_in with no load simply continues shifting.
  - bitcnt never exceeds DATA_W-1.
  - A load mid-frame restarts the frame count.
  - Reset or clr_in mid-frame discards the partial frame, and no byte_done_out is produced.
  - Back-to-back completions, with next_in on consecutive cycles, give a byte_done_out pulse per frame.
- All outputs are registered except bit_out, which is a direct register bit.

Test Plan:
- Address match, read. DATA_W=8, ADDR=7'h48. After clr_in, shift 8'h91 MSB-first with one idle cycle between strobes. Required response:
  - byte_done_out high for exactly one cycle after the 8th edge.
  - data_out=8'h91, addrok_out=1, rw_out=1, gcall_out=0.
  - A second frame 8'h00 leaves the flags unchanged.
- General call. Shift 8'h00 after clr_in → addrok_out=1, gcall_out=1, rw_out=0. With GC_EN=0: addrok_out=0.
- Mismatch and mask:
  - 8'h92 (addr 7'h49) → addrok_out=0.
  - With ADDR_MASK=7'h7C, 8'h97 (addr 7'h4B) → addrok_out=1.
- Transmit. load_in with tx_data_in=8'hA5, then 8 next_in with bit_in=bit_out. Required response:
  - bit_out sequence is 1,0,1,0,0,1,0,1.
  - data_out=8'hA5 and byte_done_out pulses once.
- Mid-frame abort and priority:
  - After 3 shifted bits, assert rst_n=0 asynchronously between edges → all outputs 0 immediately.
  - Repeat with clr_in → bitcnt_out=0 and no byte_done_out.
  - load_in and next_in in the same cycle → load wins and bitcnt_out=0.
